// File: rtl/bpm_display.sv
// BPM value to 3-digit multiplexed 7-segment display: saturating capture, sequential
// double-dabble conversion with one-deep pending slot, tp-paced digit scan with blanking.
module bpm_display #(
   parameter int BPM_MAX  = 250,
   parameter int BPM_SIZE = 8,
   parameter int DIGIT_TP = 195
) (
   input  logic                clk_i,
   input  logic                rst,
   input  logic                tp_i,
   input  logic [BPM_SIZE-1:0] bpm_i,
   input  logic                bpm_valid,
   output logic [6:0]          seg_o,
   output logic [2:0]          dig_o,
   output logic                busy_o
);
   localparam int TPW = $clog2(DIGIT_TP + 1);
   localparam int CW  = $clog2(BPM_SIZE + 1);
   localparam logic [BPM_SIZE-1:0] MAX_V     = BPM_MAX[BPM_SIZE-1:0];
   localparam logic [TPW-1:0]      TP_LAST   = TPW'(DIGIT_TP - 1);
   localparam logic [CW-1:0]       CONV_LAST = CW'(BPM_SIZE - 1);

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

   state_t              state_q, state_d;
   logic [BPM_SIZE-1:0] shift_q, shift_d;
   logic [11:0]         bcd_q, bcd_d;
   logic [11:0]         bcd_adj;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BPM_SIZE-1:0] pend_val_q, pend_val_d;
   logic                pending_q, pending_d;
   logic [11:0]         shown_q, shown_d;
   logic [TPW-1:0]      tp_cnt_q, tp_cnt_d;
   logic [1:0]          idx_q, idx_d;
   logic [6:0]          seg_q, seg_d;
   logic [2:0]          dig_q, dig_d;
   logic                busy_q, busy_d;
   logic [BPM_SIZE-1:0] bpm_sat;
   logic [3:0]          nib;
   logic                blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         default: seg_decode = 7'h00;
      endcase
   endfunction

   assign bpm_sat = (bpm_i > MAX_V) ? MAX_V : bpm_i;

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                              : bcd_q[gi*4 +: 4];
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      pend_val_d = pend_val_q;
      pending_d  = pending_q;
      shown_d    = shown_q;
      case (state_q)
         S_IDLE: begin
            if (bpm_valid) begin
               shift_d = bpm_sat;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            {bcd_d, shift_d} = {bcd_adj[10:0], shift_q, 1'b0};
            cnt_d            = cnt_q + CW'(1);
            if (cnt_q == CONV_LAST) state_d = S_LOAD;
            if (bpm_valid) begin
               pending_d  = 1'b1;
               pend_val_d = bpm_sat;
            end
         end
         S_LOAD: begin
            shown_d = bcd_q;
            // A strobe arriving during LOAD is newer than anything pending.
            if (bpm_valid || pending_q) begin
               shift_d   = bpm_valid ? bpm_sat : pend_val_q;
               bcd_d     = '0;
               cnt_d     = '0;
               pending_d = 1'b0;
               state_d   = S_CONV;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tp_cnt_d = tp_cnt_q;
      idx_d    = idx_q;
      if (tp_i) begin
         if (tp_cnt_q == TP_LAST) begin
            tp_cnt_d = '0;
            idx_d    = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
         end else begin
            tp_cnt_d = tp_cnt_q + TPW'(1);
         end
      end
   end

   always_comb begin
      nib   = shown_q[3:0];
      blank = 1'b0;
      case (idx_d)
         2'd1: begin
            nib   = shown_q[7:4];
            blank = (shown_q[11:8] == 4'd0) && (shown_q[7:4] == 4'd0);
         end
         2'd2: begin
            nib   = shown_q[11:8];
            blank = (shown_q[11:8] == 4'd0);
         end
         default: ;
      endcase
      dig_d  = 3'b001 << idx_d;
      seg_d  = blank ? 7'h00 : seg_decode(nib);
      busy_d = (state_d != S_IDLE) | pending_d;
   end

   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         pend_val_q <= '0;
         pending_q  <= 1'b0;
         shown_q    <= '0;
         tp_cnt_q   <= '0;
         idx_q      <= '0;
         seg_q      <= 7'h3F;
         dig_q      <= 3'b001;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         pend_val_q <= pend_val_d;
         pending_q  <= pending_d;
         shown_q    <= shown_d;
         tp_cnt_q   <= tp_cnt_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         dig_q      <= dig_d;
         busy_q     <= busy_d;
      end
   end

   assign seg_o  = seg_q;
   assign dig_o  = dig_q;
   assign busy_o = busy_q;
endmodule

// File: tb/tb_bpm_display.sv
// Self-checking bench for bpm_display with a short scan period (DIGIT_TP=3).
module tb_bpm_display;
   logic       clk_i = 1'b0;
   logic       rst;
   logic       tp_i;
   logic [7:0] bpm_i;
   logic       bpm_valid;
   logic [6:0] seg_o;
   logic [2:0] dig_o;
   logic       busy_o;

   always #5 clk_i = ~clk_i;

   bpm_display #(.BPM_MAX(250), .BPM_SIZE(8), .DIGIT_TP(3)) dut (
      .clk_i    (clk_i),
      .rst      (rst),
      .tp_i     (tp_i),
      .bpm_i    (bpm_i),
      .bpm_valid(bpm_valid),
      .seg_o    (seg_o),
      .dig_o    (dig_o),
      .busy_o   (busy_o)
   );

   typedef struct {
      logic [7:0] bpm;
      logic [6:0] u;
      logic [6:0] t;
      logic [6:0] h;
   } vec_t;

   vec_t vecs [12];
   vec_t sb [$];
   int   errs   = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // Pulse tp every cycle until each digit slot has been observed once.
   task automatic read_display(output logic [6:0] su, output logic [6:0] st, output logic [6:0] sh);
      logic [2:0] seen;
      seen = 3'b000;
      su = 7'h00;
      st = 7'h00;
      sh = 7'h00;
      for (int c = 0; c < 40 && seen != 3'b111; c++) begin
         chk("dig_onehot", {31'd0, $onehot(dig_o)}, 32'd1);
         case (dig_o)
            3'b001: su = seg_o;
            3'b010: st = seg_o;
            3'b100: sh = seg_o;
            default: ;
         endcase
         seen = seen | dig_o;
         tp_i = 1'b1;
         tick();
      end
      tp_i = 1'b0;
      chk("scan_complete", {29'd0, seen}, 32'd7);
   endtask

   task automatic run_vec(input vec_t v);
      vec_t       e;
      int         nb;
      logic [6:0] su, st, sh;
      bpm_i     = v.bpm;
      bpm_valid = 1'b1;
      sb.push_back(v);
      tick();
      bpm_valid = 1'b0;
      nb = 0;
      for (int c = 0; c < 30 && busy_o; c++) begin
         nb++;
         tick();
      end
      chk("busy_cycles", nb, 9);
      e = sb.pop_front();
      read_display(su, st, sh);
      $display("vec bpm=%0d seg u=%h t=%h h=%h", e.bpm, su, st, sh);
      chk("units", su, e.u);
      chk("tens", st, e.t);
      chk("hundreds", sh, e.h);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [6:0] su, st, sh;
      logic [6:0] exp_seg;
      int         nb, exp_idx;
      logic       done, seen60;

      vecs[0]  = '{8'd120, 7'h3F, 7'h5B, 7'h06};
      vecs[1]  = '{8'd7,   7'h07, 7'h00, 7'h00};
      vecs[2]  = '{8'd105, 7'h6D, 7'h3F, 7'h06};
      vecs[3]  = '{8'd255, 7'h3F, 7'h6D, 7'h5B};
      vecs[4]  = '{8'd250, 7'h3F, 7'h6D, 7'h5B};
      vecs[5]  = '{8'd0,   7'h3F, 7'h00, 7'h00};
      vecs[6]  = '{8'd99,  7'h6F, 7'h6F, 7'h00};
      vecs[7]  = '{8'd200, 7'h3F, 7'h3F, 7'h5B};
      vecs[8]  = '{8'd10,  7'h3F, 7'h06, 7'h00};
      vecs[9]  = '{8'd48,  7'h7F, 7'h66, 7'h00};
      vecs[10] = '{8'd136, 7'h7D, 7'h4F, 7'h06};
      vecs[11] = '{8'd251, 7'h3F, 7'h6D, 7'h5B};

      // Reset and idle: outputs frozen with no tp
      rst = 1'b1; tp_i = 1'b0; bpm_valid = 1'b0; bpm_i = 8'd0;
      repeat (3) tick();
      chk("rst_dig", dig_o, 3'b001);
      chk("rst_seg", seg_o, 7'h3F);
      chk("rst_busy", busy_o, 1'b0);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("idle_dig", dig_o, 3'b001);
         chk("idle_seg", seg_o, 7'h3F);
         chk("idle_busy", busy_o, 1'b0);
      end

      // Table of single conversions
      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      // 100, then 60 at CONV cycle 3, then 75 at CONV cycle 5, with tp every cycle
      bpm_i = 8'd100; bpm_valid = 1'b1;
      tick();
      bpm_valid = 1'b0;
      nb = 0; done = 1'b0; seen60 = 1'b0;
      for (int k = 1; k <= 40 && !done; k++) begin
         if (busy_o) nb++;
         else done = 1'b1;
         if (dig_o == 3'b010 && seg_o == 7'h7D) seen60 = 1'b1;
         if (k >= 11 && k <= 19) begin
            exp_seg = (dig_o == 3'b100) ? 7'h06 : 7'h3F;
            chk("t5_first_shown", seg_o, exp_seg);
         end
         bpm_valid = (k == 3) || (k == 5);
         bpm_i     = (k == 3) ? 8'd60 : 8'd75;
         tp_i      = 1'b1;
         tick();
      end
      tp_i = 1'b0; bpm_valid = 1'b0;
      chk("t5_busy_cycles", nb, 18);
      chk("t5_60_never_shown", seen60, 1'b0);
      read_display(su, st, sh);
      $display("t5 final seg u=%h t=%h h=%h", su, st, sh);
      chk("t5_units", su, 7'h6D);
      chk("t5_tens", st, 7'h07);
      chk("t5_hundreds", sh, 7'h00);

      // Scan pacing: tp every 4 clocks, digit advances on every 3rd tp
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      exp_idx = 0;
      for (int j = 1; j <= 9; j++) begin
         tp_i = 1'b1;
         tick();
         tp_i = 1'b0;
         if (j % 3 == 0) exp_idx = (exp_idx + 1) % 3;
         chk("scan_step", dig_o, 32'(1 << exp_idx));
         repeat (3) begin
            tick();
            chk("scan_hold", dig_o, 32'(1 << exp_idx));
         end
      end
      $display("scan sequence done, slot=%0d", exp_idx);

      // Asynchronous reset in the middle of converting 200
      bpm_i = 8'd200; bpm_valid = 1'b1;
      tick();
      bpm_valid = 1'b0;
      tick();
      tick();
      chk("midconv_busy", busy_o, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_dig", dig_o, 3'b001);
      chk("arst_seg", seg_o, 7'h3F);
      chk("arst_busy", busy_o, 1'b0);
      tick();
      rst = 1'b0;
      repeat (12) tick();
      chk("arst_no_resume", busy_o, 1'b0);
      read_display(su, st, sh);
      $display("after reset seg u=%h t=%h h=%h", su, st, sh);
      chk("arst_units", su, 7'h3F);
      chk("arst_tens", st, 7'h00);
      chk("arst_hundreds", sh, 7'h00);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
